// File: rtl/reg_alu_pipe.sv
// Two-stage register-file/ALU datapath: stage 1 reads operands (with forwarding),
// stage 2 executes and writes back. Define REG_ALU_R0_ZERO_EN to hardwire register 0 to zero.
module reg_alu_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              sel,
  input  logic              wr,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out_a,
  output logic [DATA_W-1:0] d_out_b,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              cout,
  output logic              zero
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpAdc = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } op_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Stage-1 pipeline registers
  op_e               op_q;
  logic              sel_q;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] d_in_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] d_out_a_q, d_out_b_q;

  // Stage-2 state
  logic [DATA_W-1:0] result_q;
  logic              result_valid_q;
  logic              cout_q;
  logic              zero_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W-1:0] wb_val;
  logic              wb_en;
  logic [DATA_W-1:0] rd_a_val, rd_b_val;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_q)
      OpAdd: begin
        sum     = {1'b0, d_out_a_q} + {1'b0, d_out_b_q};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpSub: begin
        sum     = {1'b0, d_out_a_q} + {1'b0, ~d_out_b_q} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpAnd: alu_res = d_out_a_q & d_out_b_q;
      OpOr:  alu_res = d_out_a_q | d_out_b_q;
      OpXor: alu_res = d_out_a_q ^ d_out_b_q;
      OpAdc: begin
        // Carry-in is the flag register, already updated by the previous op
        sum     = {1'b0, d_out_a_q} + {1'b0, d_out_b_q} + {{DATA_W{1'b0}}, cout_q};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpShl: begin
        alu_res = {d_out_a_q[DATA_W-2:0], 1'b0};
        alu_c   = d_out_a_q[DATA_W-1];
      end
      OpShr: begin
        alu_res = {1'b0, d_out_a_q[DATA_W-1:1]};
        alu_c   = d_out_a_q[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  assign wb_val = sel_q ? alu_res : d_in_q;

`ifdef REG_ALU_R0_ZERO_EN
  assign wb_en = s1_valid_q & wr_q & (wr_addr_q != '0);
`else
  assign wb_en = s1_valid_q & wr_q;
`endif

  // Operand read with bypass from the write landing on the same edge
  always_comb begin
    rd_a_val = mem_q[rd_addr_a];
    rd_b_val = mem_q[rd_addr_b];
    if (wb_en && (wr_addr_q == rd_addr_a)) rd_a_val = wb_val;
    if (wb_en && (wr_addr_q == rd_addr_b)) rd_b_val = wb_val;
`ifdef REG_ALU_R0_ZERO_EN
    if (rd_addr_a == '0) rd_a_val = '0;
    if (rd_addr_b == '0) rd_b_val = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      op_q           <= OpAdd;
      sel_q          <= 1'b0;
      wr_q           <= 1'b0;
      wr_addr_q      <= '0;
      d_in_q         <= '0;
      s1_valid_q     <= 1'b0;
      d_out_a_q      <= '0;
      d_out_b_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      cout_q         <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        op_q      <= op_e'(op);
        sel_q     <= sel;
        wr_q      <= wr;
        wr_addr_q <= wr_addr;
        d_in_q    <= d_in;
        d_out_a_q <= rd_a_val;
        d_out_b_q <= rd_b_val;
      end

      result_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= wb_val;
        if (sel_q) begin
          cout_q <= alu_c;
          zero_q <= (alu_res == '0);
        end
      end
      if (wb_en) mem_q[wr_addr_q] <= wb_val;
    end
  end

  assign d_out_a      = d_out_a_q;
  assign d_out_b      = d_out_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign cout         = cout_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed-vector bench for reg_alu_pipe (default 8-bit data, 8 registers).
module tb_reg_alu_pipe;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in, sel, wr;
  logic [2:0] op, rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] d_in, d_out_a, d_out_b, result;
  logic       result_valid, cout, zero;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_r0_a, exp_r0_b;

  reg_alu_pipe #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .result(result), .result_valid(result_valid),
    .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic s, input logic w, input logic [2:0] o,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                     input logic [7:0] din);
    valid_in = v; sel = s; wr = w; op = o;
    rd_addr_a = ra; rd_addr_b = rb; wr_addr = wa; d_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 1'b0, 1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h00);
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] r, input logic c, input logic z);
    chk_d({tag, "_result"}, result, r);
    chk_b({tag, "_valid"}, result_valid, 1'b1);
    chk_b({tag, "_cout"}, cout, c);
    chk_b({tag, "_zero"}, zero, z);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    nop();
    reset = 1'b0;
    chk_d("rst_result", result, 8'h00);
    chk_b("rst_valid", result_valid, 1'b0);
    chk_b("rst_cout", cout, 1'b0);
    chk_b("rst_zero", zero, 1'b0);
    chk_d("rst_a", d_out_a, 8'h00);
    chk_d("rst_b", d_out_b, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'(i), 3'(7 - i), 3'd0, 8'h00);
      chk_d("rst_read_a", d_out_a, 8'h00);
      chk_d("rst_read_b", d_out_b, 8'h00);
    end

    // External write r3=CD, then read back
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd3, 8'hCD);
    nop();
    chk_d("wr3_result", result, 8'hCD);
    chk_b("wr3_valid", result_valid, 1'b1);
    chk_b("wr3_cout_hold", cout, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd3, 3'd0, 3'd0, 8'h00);
    chk_d("rd3", d_out_a, 8'hCD);

    // r1=E2 then forwarded ADD r1,r3 -> r5
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd1, 8'hE2);
    cyc(1'b1, 1'b1, 1'b1, OP_ADD, 3'd1, 3'd3, 3'd5, 8'h00);
    chk_d("fwd_a", d_out_a, 8'hE2);
    chk_d("fwd_b", d_out_b, 8'hCD);
    cyc(1'b1, 1'b1, 1'b0, OP_ADC, 3'd1, 3'd2, 3'd0, 8'h00);
    chk_flags("add", 8'hAF, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, OP_SUB, 3'd3, 3'd3, 3'd0, 8'h00);
    chk_flags("adc", 8'hE3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd5, 3'd0, 3'd0, 8'h00);
    chk_flags("sub_eq", 8'h00, 1'b1, 1'b1);
    chk_d("rd5", d_out_a, 8'hAF);

    // Logic ops clear carry; sel=0 op holds flags
    cyc(1'b1, 1'b1, 1'b0, OP_AND, 3'd1, 3'd3, 3'd0, 8'h00);
    chk_flags("sel0_hold", 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, OP_OR, 3'd1, 3'd3, 3'd0, 8'h00);
    chk_flags("and", 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, OP_XOR, 3'd1, 3'd3, 3'd0, 8'h00);
    chk_flags("or", 8'hEF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, OP_SUB, 3'd2, 3'd1, 3'd0, 8'h00);
    chk_flags("xor", 8'h2F, 1'b0, 1'b0);

    // Shifts: r4=01, r7=80
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd4, 8'h01);
    chk_flags("sub_borrow", 8'h1E, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd7, 8'h80);
    cyc(1'b1, 1'b1, 1'b0, OP_ADD, 3'd2, 3'd2, 3'd0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, OP_SHL, 3'd7, 3'd0, 3'd0, 8'h00);
    chk_flags("add_zero", 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, OP_ADD, 3'd2, 3'd2, 3'd0, 8'h00);
    chk_flags("shl", 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, OP_SHR, 3'd4, 3'd0, 3'd0, 8'h00);
    chk_b("add_zero2_cout", cout, 1'b0);
    nop();
    chk_flags("shr", 8'h00, 1'b1, 1'b1);

    // valid_in=0 must not write
    cyc(1'b0, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h55);
    nop();
    chk_b("inv_valid", result_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd2, 3'd0, 3'd0, 8'h00);
    chk_d("inv_nowrite", d_out_a, 8'h00);

    // Same-address read/write in one op returns the old value
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd2, 3'd0, 3'd2, 8'hAA);
    chk_d("rw_same_old", d_out_a, 8'h00);
    nop();
    chk_d("rw_same_result", result, 8'hAA);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd2, 3'd0, 3'd0, 8'h00);
    chk_d("rw_same_new", d_out_a, 8'hAA);
    nop();
    nop();
    chk_b("idle_valid", result_valid, 1'b0);
    chk_d("idle_result_hold", result, 8'h00);
    chk_d("idle_a_hold", d_out_a, 8'hAA);

    // Reset drops an in-flight write to r6
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd6, 8'h77);
    reset = 1'b1;
    nop();
    reset = 1'b0;
    chk_b("mid_rst_valid", result_valid, 1'b0);
    chk_d("mid_rst_result", result, 8'h00);
    chk_d("mid_rst_a", d_out_a, 8'h00);
    nop();
    chk_b("mid_rst_valid2", result_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd6, 3'd1, 3'd0, 8'h00);
    chk_d("rst_r6", d_out_a, 8'h00);
    chk_d("rst_r1", d_out_b, 8'h00);

    // Register 0 behaviour
`ifdef REG_ALU_R0_ZERO_EN
    exp_r0_a = 8'h00;
    exp_r0_b = 8'h00;
`else
    exp_r0_a = 8'h12;
    exp_r0_b = 8'h34;
`endif
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h12);
    nop();
    chk_d("r0_wr_result", result, 8'h12);
    chk_b("r0_wr_valid", result_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h00);
    chk_d("r0_read", d_out_a, exp_r0_a);
    cyc(1'b1, 1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h34);
    cyc(1'b1, 1'b0, 1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h00);
    chk_d("r0_fwd", d_out_b, exp_r0_b);
    nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
